// File: rtl/buf_pkg.sv
// Shared geometry and types for the buffer M1 responder and its lane RAMs.
package buf_pkg;
    localparam int N_BUF  = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int DATA_W = 16;

    typedef enum logic {BR_IDLE, BR_CLEAR} buf_resp_state_t;

    typedef logic [ADDR_W-1:0] buf_addr_t;
    typedef logic [DATA_W-1:0] buf_word_t;
endpackage

// File: rtl/buffer_lane_ram.sv
// One 1R1W synchronous RAM lane: read-first, registered read port, contents never reset.
module buffer_lane_ram #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Both updates share one edge, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/buffer_m1_responder.sv
// Buffer M1 responder: N_BUF independent RAM lanes with a bank-clear engine and range checks.
// Define BUF_RDW_BYPASS_EN for write-first read-during-write; the default build is read-first.
module buffer_m1_responder #(
    parameter int N_BUF  = buf_pkg::N_BUF,
    parameter int ADDR_W = buf_pkg::ADDR_W,
    parameter int DEPTH  = buf_pkg::DEPTH,
    parameter int DATA_W = buf_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BUF-1:0]           m1_r_en,
    input  logic [N_BUF*ADDR_W-1:0]    m1_r_addr,
    input  logic [N_BUF-1:0]           m1_w_en,
    input  logic [N_BUF*ADDR_W-1:0]    m1_w_addr,
    input  logic [N_BUF*DATA_W-1:0]    m1_w_data,
    output logic [N_BUF*DATA_W-1:0]    m1_r_data,
    output logic [N_BUF-1:0]           m1_r_valid,
    input  logic                       clear_start,
    output logic                       busy,
    output logic                       addr_err,
    output logic [15:0]                err_cnt
);
    import buf_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    buf_resp_state_t   state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
    logic              addr_err_reg, addr_err_next;
    logic [15:0]       err_cnt_reg, err_cnt_next;
    logic [N_BUF-1:0]  r_valid_reg, r_valid_next;
    logic [N_BUF-1:0]  primed_reg, primed_next;

    logic [N_BUF-1:0]  rd_acc, wr_acc, rd_rej, wr_rej;
    logic              clearing;

    assign clearing = (state_reg == BR_CLEAR);

    genvar gi;
    generate
        for (gi = 0; gi < N_BUF; gi++) begin : g_lane
            logic [ADDR_W-1:0] r_addr, w_addr, ram_waddr;
            logic [DATA_W-1:0] w_data, ram_wdata, ram_rdata, lane_data;
            logic              rd_in_range, wr_in_range, ram_we;

            assign r_addr = m1_r_addr[gi*ADDR_W +: ADDR_W];
            assign w_addr = m1_w_addr[gi*ADDR_W +: ADDR_W];
            assign w_data = m1_w_data[gi*DATA_W +: DATA_W];

            assign rd_in_range = ({1'b0, r_addr} < DEPTH_EXT);
            assign wr_in_range = ({1'b0, w_addr} < DEPTH_EXT);

            assign rd_acc[gi] = m1_r_en[gi] & ~clearing & rd_in_range;
            assign wr_acc[gi] = m1_w_en[gi] & ~clearing & wr_in_range;
            assign rd_rej[gi] = m1_r_en[gi] & (clearing | ~rd_in_range);
            assign wr_rej[gi] = m1_w_en[gi] & (clearing | ~wr_in_range);

            // The clear engine owns the write port of every lane while busy.
            assign ram_we    = clearing | wr_acc[gi];
            assign ram_waddr = clearing ? clr_ptr_reg : w_addr;
            assign ram_wdata = clearing ? '0 : w_data;

            buffer_lane_ram #(
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH),
                .DATA_W (DATA_W)
            ) u_ram (
                .clk   (clk),
                .we    (ram_we),
                .waddr (ram_waddr),
                .wdata (ram_wdata),
                .re    (rd_acc[gi]),
                .raddr (r_addr),
                .rdata (ram_rdata)
            );

`ifdef BUF_RDW_BYPASS_EN
            logic              byp_sel_reg;
            logic [DATA_W-1:0] byp_data_reg;

            // Captured alongside the RAM read so both hold until the next accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byp_sel_reg  <= 1'b0;
                    byp_data_reg <= '0;
                end else if (rd_acc[gi]) begin
                    byp_sel_reg  <= wr_acc[gi] && (w_addr == r_addr);
                    byp_data_reg <= w_data;
                end
            end

            assign lane_data = byp_sel_reg ? byp_data_reg : ram_rdata;
`else
            assign lane_data = ram_rdata;
`endif

            // The RAM output register is not reset; mask it until the lane's first read.
            assign m1_r_data[gi*DATA_W +: DATA_W] = primed_reg[gi] ? lane_data : '0;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        clr_ptr_next  = clr_ptr_reg;
        err_cnt_next  = err_cnt_reg;
        addr_err_next = |{rd_rej, wr_rej};
        r_valid_next  = rd_acc;
        primed_next   = primed_reg | rd_acc;

        case (state_reg)
            BR_IDLE: begin
                if (clear_start) begin
                    state_next   = BR_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            BR_CLEAR: begin
                if (clr_ptr_reg == LAST_ADDR) begin
                    state_next   = BR_IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr_reg + 1'b1;
                end
            end
            default: begin
                state_next = BR_IDLE;
            end
        endcase

        if (addr_err_next && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BR_IDLE;
            clr_ptr_reg  <= '0;
            addr_err_reg <= 1'b0;
            err_cnt_reg  <= '0;
            r_valid_reg  <= '0;
            primed_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            clr_ptr_reg  <= clr_ptr_next;
            addr_err_reg <= addr_err_next;
            err_cnt_reg  <= err_cnt_next;
            r_valid_reg  <= r_valid_next;
            primed_reg   <= primed_next;
        end
    end

    assign busy       = clearing;
    assign addr_err   = addr_err_reg;
    assign err_cnt    = err_cnt_reg;
    assign m1_r_valid = r_valid_reg;
endmodule

// File: tb/tb_buffer_m1_responder.sv
// Self-checking bench for buffer_m1_responder against a per-word array model of the lanes.
// DEPTH is reduced below 2**ADDR_W so that out-of-range addresses can be expressed.
module tb_buffer_m1_responder;
    localparam int N  = 8;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int D  = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m1_r_en, m1_w_en, m1_r_valid;
    logic [N*AW-1:0]   m1_r_addr, m1_w_addr;
    logic [N*DW-1:0]   m1_w_data, m1_r_data;
    logic              clear_start, busy, addr_err;
    logic [15:0]       err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mdl_mem [N][D];
    logic [DW-1:0] exp_rdata [N];
    logic [N-1:0]  exp_valid;
    logic          exp_busy, exp_err;
    int            exp_cnt, clr_left;

    buffer_m1_responder #(
        .N_BUF (N), .ADDR_W (AW), .DEPTH (D), .DATA_W (DW)
    ) dut (
        .clk (clk), .rst (rst),
        .m1_r_en (m1_r_en), .m1_r_addr (m1_r_addr),
        .m1_w_en (m1_w_en), .m1_w_addr (m1_w_addr), .m1_w_data (m1_w_data),
        .m1_r_data (m1_r_data), .m1_r_valid (m1_r_valid),
        .clear_start (clear_start), .busy (busy),
        .addr_err (addr_err), .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] exp_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_rdata[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) exp_rdata[i] = '0;
        exp_valid = '0; exp_busy = 1'b0; exp_err = 1'b0;
        exp_cnt = 0; clr_left = 0;
    endtask

    // One clock of the specified behaviour, applied to the inputs currently driven.
    task automatic model_step();
        bit busy_now, rej;
        int ra, wa;
        busy_now = (clr_left > 0);
        rej = 1'b0;
        exp_valid = '0;
        for (int i = 0; i < N; i++) begin
            ra = int'(m1_r_addr[i*AW +: AW]);
            wa = int'(m1_w_addr[i*AW +: AW]);
            if (m1_r_en[i]) begin
                if (busy_now || ra >= D) rej = 1'b1;
                else begin
                    exp_valid[i] = 1'b1;
                    exp_rdata[i] = mdl_mem[i][ra];
`ifdef BUF_RDW_BYPASS_EN
                    if (m1_w_en[i] && wa == ra) exp_rdata[i] = m1_w_data[i*DW +: DW];
`endif
                end
            end
            if (m1_w_en[i]) begin
                if (busy_now || wa >= D) rej = 1'b1;
                else mdl_mem[i][wa] = m1_w_data[i*DW +: DW];
            end
        end
        if (busy_now) begin
            for (int i = 0; i < N; i++) mdl_mem[i][D - clr_left] = '0;
            clr_left--;
        end else if (clear_start) begin
            clr_left = D;
        end
        exp_busy = (clr_left > 0);
        exp_err  = rej;
        if (rej && exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic idle_inputs();
        m1_r_en = '0; m1_w_en = '0; m1_r_addr = '0; m1_w_addr = '0;
        m1_w_data = '0; clear_start = 1'b0;
    endtask

    task automatic set_rd(input int i, input int a);
        m1_r_en[i] = 1'b1;
        m1_r_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int i, input int a, input logic [DW-1:0] d);
        m1_w_en[i] = 1'b1;
        m1_w_addr[i*AW +: AW] = AW'(a);
        m1_w_data[i*DW +: DW] = d;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m1_r_data !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", m1_r_data); end
        checks++; if (m1_r_valid !== '0) begin errors++; $display("FAIL reset_valid: got %h expected 0", m1_r_valid); end
        checks++; if ({busy, addr_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got busy=%b err=%b expected 0 0", busy, addr_err); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
        rst = 1'b0;
        $display("reset: done");
    endtask

    // Full clear, optionally injecting a write at a given busy cycle; returns busy cycle count.
    task automatic run_clear(input int inject_at, output int n);
        n = 0;
        clear_start = 1'b1;
        step();
        while (busy === 1'b1 && n < D + 20) begin
            n++;
            if (n == inject_at) set_wr(1, 3, 16'hFFFF);
            step();
        end
    endtask

    task automatic test_init_clear();
        int n;
        run_clear(-1, n);
        checks++; if (n !== D) begin errors++; $display("FAIL clear_len: got %0d expected %0d", n, D); end
        $display("init clear: busy %0d cycles", n);
    endtask

    task automatic test_write_read();
        set_wr(0, 5, 16'h1234);
        step();
        set_rd(0, 5);
        step();
        checks++; if (m1_r_valid !== 8'h01) begin errors++; $display("FAIL wr_rd_valid: got %h expected 01", m1_r_valid); end
        checks++; if (m1_r_data[15:0] !== 16'h1234) begin errors++; $display("FAIL wr_rd_data: got %h expected 1234", m1_r_data[15:0]); end
        step();
        checks++; if (m1_r_valid !== 8'h00) begin errors++; $display("FAIL wr_rd_valid_drop: got %h expected 00", m1_r_valid); end
        checks++; if (m1_r_data[15:0] !== 16'h1234) begin errors++; $display("FAIL wr_rd_hold: got %h expected 1234", m1_r_data[15:0]); end
        $display("write/read lane0 addr5: data %h", m1_r_data[15:0]);
    endtask

    task automatic test_all_lanes();
        logic [DW-1:0] want;
        for (int i = 0; i < N; i++) set_wr(i, 7, 16'h00A0 + 16'(i));
        step();
        for (int i = 0; i < N; i++) set_rd(i, 7);
        step();
        checks++; if (m1_r_valid !== 8'hFF) begin errors++; $display("FAIL all_valid: got %h expected ff", m1_r_valid); end
        for (int i = 0; i < N; i++) begin
            want = 16'h00A0 + 16'(i);
            checks++;
            if (m1_r_data[i*DW +: DW] !== want) begin errors++; $display("FAIL all_lane%0d: got %h expected %h", i, m1_r_data[i*DW +: DW], want); end
        end
        $display("all lanes addr7: %h", m1_r_data);
    endtask

    task automatic test_rdw();
        logic [DW-1:0] want;
`ifdef BUF_RDW_BYPASS_EN
        want = 16'h5555;
`else
        want = 16'hAAAA;
`endif
        set_wr(3, 9, 16'hAAAA);
        step();
        set_rd(3, 9);
        set_wr(3, 9, 16'h5555);
        step();
        checks++; if (m1_r_data[3*DW +: DW] !== want) begin errors++; $display("FAIL rdw_same_cycle: got %h expected %h", m1_r_data[3*DW +: DW], want); end
        set_rd(3, 9);
        step();
        checks++; if (m1_r_data[3*DW +: DW] !== 16'h5555) begin errors++; $display("FAIL rdw_after: got %h expected 5555", m1_r_data[3*DW +: DW]); end
        $display("rdw lane3 addr9: %h", m1_r_data[3*DW +: DW]);
    endtask

    task automatic test_range_err();
        int prev;
        prev = exp_cnt;
        set_rd(2, D);
        set_wr(2, D, 16'hDEAD);
        step();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL range_err_pulse: got %b expected 1", addr_err); end
        checks++; if (m1_r_valid[2] !== 1'b0) begin errors++; $display("FAIL range_valid: got %b expected 0", m1_r_valid[2]); end
        checks++; if (err_cnt !== 16'(prev + 1)) begin errors++; $display("FAIL range_errcnt: got %0d expected %0d", err_cnt, prev + 1); end
        set_rd(2, 7);
        step();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL range_err_once: got %b expected 0", addr_err); end
        checks++; if (m1_r_data[2*DW +: DW] !== 16'h00A2) begin errors++; $display("FAIL range_contents: got %h expected 00a2", m1_r_data[2*DW +: DW]); end
        $display("out-of-range lane2: err_cnt %0d", err_cnt);
    endtask

    task automatic test_random();
        int a;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    a = ($urandom_range(7, 0) == 0) ? int'($urandom_range(2**AW - 1, D)) : int'($urandom_range(15, 0));
                    set_rd(i, a);
                end
                if ($urandom_range(1, 0) == 1) begin
                    a = ($urandom_range(7, 0) == 0) ? int'($urandom_range(2**AW - 1, D)) : int'($urandom_range(15, 0));
                    set_wr(i, a, DW'($urandom));
                end
            end
            step();
            checks++; if (m1_r_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c%0d: got %h expected %h", c, m1_r_valid, exp_valid); end
            checks++; if (m1_r_data !== exp_vec()) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, m1_r_data, exp_vec()); end
            checks++; if (addr_err !== exp_err) begin errors++; $display("FAIL rand_err c%0d: got %b expected %b", c, addr_err, exp_err); end
            checks++; if (err_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rand_errcnt c%0d: got %0d expected %0d", c, err_cnt, exp_cnt); end
        end
        $display("random: 600 cycles, err_cnt %0d", err_cnt);
    endtask

    task automatic test_clear_with_write();
        int n, prev;
        prev = exp_cnt;
        run_clear(10, n);
        checks++; if (n !== D) begin errors++; $display("FAIL clrw_len: got %0d expected %0d", n, D); end
        checks++; if (err_cnt !== 16'(prev + 1)) begin errors++; $display("FAIL clrw_errcnt: got %0d expected %0d", err_cnt, prev + 1); end
        for (int a = 0; a < D; a++) begin
            for (int i = 0; i < N; i++) set_rd(i, a);
            step();
            checks++;
            if (m1_r_valid !== 8'hFF || m1_r_data !== '0) begin
                errors++; $display("FAIL clrw_zero a%0d: got valid=%h data=%h expected ff 0", a, m1_r_valid, m1_r_data);
            end
        end
        $display("clear with write: busy %0d cycles, err_cnt %0d", n, err_cnt);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clear_start = 1'b1;
        step();
        repeat (99) step();
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (m1_r_data !== '0 || m1_r_valid !== '0) begin errors++; $display("FAIL midrst_read: got data=%h valid=%h expected 0 0", m1_r_data, m1_r_valid); end
        checks++; if (addr_err !== 1'b0 || err_cnt !== 16'd0) begin errors++; $display("FAIL midrst_err: got err=%b cnt=%0d expected 0 0", addr_err, err_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_clear(-1, n);
        checks++; if (n !== D) begin errors++; $display("FAIL midrst_reclear: got %0d expected %0d", n, D); end
        $display("reset mid-clear: reclear busy %0d cycles", n);
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_write_read();
        test_all_lanes();
        test_rdw();
        test_range_err();
        test_random();
        test_clear_with_write();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
